fetch_step1: RTL and testbench

//  Fetch stage of the 5-step pipeline: owns the PC, drives instruction-memory address, and holds the

---
 rtl/fetch_step1_pkg.sv | 13 +
 rtl/pc_reg_step1.sv | 28 ++
 rtl/fetch_step1.sv | 82 ++++++++
 tb/tb_fetch_step1.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_step1_pkg.sv
// Shared fetch-stage constants and the step1 control FSM state encoding.
package fetch_step1_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  typedef enum logic {
    S_BOOT = 1'b0,
    S_RUN  = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_reg_step1.sv
// Program counter with next-PC selection: a step3 redirect beats a sequential
// advance, which beats hold.
module pc_reg_step1 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        pc_load,
  input  logic        redirect,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (run) begin
      // The older instruction's redirect overrides a load-hazard stall.
      if (redirect)
        pc <= target;
      else if (pc_load)
        pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_step1.sv
// Fetch stage: owns the PC, drives the instruction-memory address and holds the
// IF/ID (step1) register plus a count of valid instructions captured.
module fetch_step1
  import fetch_step1_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_load,
  input  logic             load_step1,
  input  logic             reset_step1,
  input  logic             redirect_step3,
  input  logic [31:0]      target_step3,
  input  logic [31:0]      imem_data,
  output logic [31:0]      imem_addr,
  output logic [31:0]      instr_step1,
  output logic [31:0]      pc_step1,
  output logic [31:0]      pc_plus4_step1,
  output logic             valid_step1,
  output logic [CNT_W-1:0] fetch_count,
  output fetch_state_e     state
);

  logic [31:0] pc;

  pc_reg_step1 #(
    .RESET_PC (RESET_PC),
    .PC_STEP  (PC_STEP)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .run      (state == S_RUN),
    .pc_load  (pc_load),
    .redirect (redirect_step3),
    .target   (target_step3),
    .pc       (pc)
  );

  assign imem_addr = pc;

  // S_BOOT gives instruction memory one settle cycle; step1 stays a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= S_BOOT;
      instr_step1    <= NOP_INSTR;
      pc_step1       <= 32'h0;
      pc_plus4_step1 <= 32'h0;
      valid_step1    <= 1'b0;
      fetch_count    <= '0;
    end else begin
      case (state)
        S_BOOT: begin
          state          <= S_RUN;
          instr_step1    <= NOP_INSTR;
          pc_step1       <= 32'h0;
          pc_plus4_step1 <= 32'h0;
          valid_step1    <= 1'b0;
        end
        S_RUN: begin
          // Flush beats load; a redirect alone does not flush the wrong-path word.
          if (reset_step1) begin
            instr_step1    <= NOP_INSTR;
            pc_step1       <= 32'h0;
            pc_plus4_step1 <= 32'h0;
            valid_step1    <= 1'b0;
          end else if (load_step1) begin
            instr_step1    <= imem_data;
            pc_step1       <= pc;
            pc_plus4_step1 <= pc + PC_STEP;
            valid_step1    <= 1'b1;
            fetch_count    <= fetch_count + CNT_W'(1);
          end
        end
        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_step1.sv
// Bench for fetch_step1: directed vector table, async-reset check, then random
// stimulus against a behavioural model of the fetch stage.
module tb_fetch_step1;
  import fetch_step1_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        pc_load = 1'b0, load_step1 = 1'b0, reset_step1 = 1'b0, redirect_step3 = 1'b0;
  logic [31:0] target_step3 = 32'h0;
  logic [31:0] imem_data;
  logic [31:0] imem_addr, instr_step1, pc_step1, pc_plus4_step1, fetch_count;
  logic        valid_step1;
  fetch_state_e state;

  fetch_step1 dut (
    .clk(clk), .reset(reset), .pc_load(pc_load), .load_step1(load_step1),
    .reset_step1(reset_step1), .redirect_step3(redirect_step3),
    .target_step3(target_step3), .imem_data(imem_data), .imem_addr(imem_addr),
    .instr_step1(instr_step1), .pc_step1(pc_step1), .pc_plus4_step1(pc_plus4_step1),
    .valid_step1(valid_step1), .fetch_count(fetch_count), .state(state)
  );

  // instruction memory contents as a pure function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction
  always_comb imem_data = mem_word(imem_addr);

  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
  endtask

  // behavioural model of the stage
  logic [31:0] m_pc, m_instr, m_pc1, m_pc4, m_cnt;
  logic        m_valid, m_boot;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_pc1 = 32'h0; m_pc4 = 32'h0;
    m_cnt = 32'h0; m_valid = 1'b0; m_boot = 1'b1;
  endtask

  task automatic model_edge();
    logic [31:0] cur;
    cur = m_pc;
    if (m_boot) begin
      m_boot = 1'b0;
      m_instr = 32'h0; m_pc1 = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else begin
      if (redirect_step3) m_pc = target_step3;
      else if (pc_load)   m_pc = cur + 32'd4;
      if (reset_step1) begin
        m_instr = 32'h0; m_pc1 = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (load_step1) begin
        m_instr = mem_word(cur); m_pc1 = cur; m_pc4 = cur + 32'd4;
        m_valid = 1'b1; m_cnt = m_cnt + 32'd1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".addr"},  imem_addr,      m_pc);
    chk({tag, ".instr"}, instr_step1,    m_instr);
    chk({tag, ".pc1"},   pc_step1,       m_pc1);
    chk({tag, ".pc4"},   pc_plus4_step1, m_pc4);
    chk({tag, ".valid"}, {31'h0, valid_step1}, {31'h0, m_valid});
    chk({tag, ".count"}, fetch_count,    m_cnt);
  endtask

  // driver
  task automatic drive(input logic pl, input logic ls, input logic rs,
                       input logic rd, input logic [31:0] tg);
    pc_load = pl; load_step1 = ls; reset_step1 = rs; redirect_step3 = rd; target_step3 = tg;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  typedef struct {
    logic        pl, ls, rs, rd;
    logic [31:0] tg;
    logic [31:0] e_addr, e_pc1, e_pc4, e_cnt;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic pl, input logic ls, input logic rs, input logic rd,
                             input logic [31:0] tg, input logic [31:0] ea, input logic [31:0] ep1,
                             input logic [31:0] ep4, input logic ev, input logic [31:0] ec);
    vec_t r;
    r.pl = pl; r.ls = ls; r.rs = rs; r.rd = rd; r.tg = tg;
    r.e_addr = ea; r.e_pc1 = ep1; r.e_pc4 = ep4; r.e_valid = ev; r.e_cnt = ec;
    return r;
  endfunction

  initial begin
    // sequential fetch from reset; first edge is the boot bubble
    vecs.push_back(v(1,1,0,0,0,           32'h0,   0,       0,       0, 0));
    vecs.push_back(v(1,1,0,0,0,           32'h4,   32'h0,   32'h4,   1, 1));
    vecs.push_back(v(1,1,0,0,0,           32'h8,   32'h4,   32'h8,   1, 2));
    vecs.push_back(v(1,1,0,0,0,           32'hC,   32'h8,   32'hC,   1, 3));
    vecs.push_back(v(1,1,0,0,0,           32'h10,  32'hC,   32'h10,  1, 4));
    // stall at PC=0x10
    vecs.push_back(v(0,0,0,0,0,           32'h10,  32'hC,   32'h10,  1, 4));
    vecs.push_back(v(0,0,0,0,0,           32'h10,  32'hC,   32'h10,  1, 4));
    // redirect with flush overriding the stall
    vecs.push_back(v(0,1,1,1,32'h400,     32'h400, 0,       0,       0, 4));
    vecs.push_back(v(1,1,0,0,0,           32'h404, 32'h400, 32'h404, 1, 5));
    // flush beats load
    vecs.push_back(v(1,1,1,0,0,           32'h408, 0,       0,       0, 5));
    // PC wrap
    vecs.push_back(v(0,1,1,1,32'hFFFF_FFFC, 32'hFFFF_FFFC, 0,   0,       0, 5));
    vecs.push_back(v(1,1,0,0,0,           32'h0,   32'hFFFF_FFFC, 32'h0, 1, 6));
    vecs.push_back(v(1,1,0,0,0,           32'h4,   32'h0,   32'h4,   1, 7));
    // redirect without flush keeps the wrong-path word
    vecs.push_back(v(0,1,0,1,32'h100,     32'h100, 32'h4,   32'h8,   1, 8));
    vecs.push_back(v(0,0,0,0,0,           32'h100, 32'h4,   32'h8,   1, 8));

    do_reset();
    chk("reset.state", {31'h0, state}, {31'h0, S_BOOT});
    chk("reset.addr", imem_addr, 32'h0);
    chk("reset.valid", {31'h0, valid_step1}, 32'h0);
    chk("reset.count", fetch_count, 32'h0);

    foreach (vecs[i]) begin
      drive(vecs[i].pl, vecs[i].ls, vecs[i].rs, vecs[i].rd, vecs[i].tg);
      @(posedge clk); #1;
      chk($sformatf("vec%0d.addr", i),  imem_addr, vecs[i].e_addr);
      chk($sformatf("vec%0d.pc1", i),   pc_step1, vecs[i].e_pc1);
      chk($sformatf("vec%0d.pc4", i),   pc_plus4_step1, vecs[i].e_pc4);
      chk($sformatf("vec%0d.valid", i), {31'h0, valid_step1}, {31'h0, vecs[i].e_valid});
      chk($sformatf("vec%0d.count", i), fetch_count, vecs[i].e_cnt);
      chk($sformatf("vec%0d.instr", i), instr_step1,
          vecs[i].e_valid ? mem_word(vecs[i].e_pc1) : 32'h0);
    end

    // asynchronous reset between edges takes effect without a clock
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("async.addr",  imem_addr, 32'h0);
    chk("async.instr", instr_step1, 32'h0);
    chk("async.pc1",   pc_step1, 32'h0);
    chk("async.pc4",   pc_plus4_step1, 32'h0);
    chk("async.valid", {31'h0, valid_step1}, 32'h0);
    chk("async.count", fetch_count, 32'h0);
    chk("async.state", {31'h0, state}, {31'h0, S_BOOT});
    @(negedge clk);
    reset = 1'b0;

    // random phase against the model
    model_reset();
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        @(negedge clk);
        reset = 1'b1;
        #2;
        model_reset();
        check_model("rnd_rst");
        reset = 1'b0;
      end
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
            $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0,
            ($urandom_range(0, 4) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                        : $urandom & 32'h0000_FFFC);
      @(posedge clk);
      model_edge();
      #1;
      check_model($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

endmodule
